// File: rtl/ivl_uvm_win_event_gen_if.sv
// Command channel of the window event generator.
// A requester (master) offers one window command with cmd_valid and the
// generator (slave) takes it on a clock edge where cmd_ready is also high.
//   cmd_valid  : command offered
//   cmd_ready  : generator idle and able to take a command
//   cmd_pre    : idle cycles before start_event
//   cmd_len    : open-window cycles between start_event and end_event
//   cmd_change : apply cmd_data to test_expr inside the window
//   cmd_data   : value for test_expr when cmd_change is set
interface ivl_uvm_win_event_gen_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_pre;
  logic [CNT_W-1:0] cmd_len;
  logic             cmd_change;
  logic [WIDTH-1:0] cmd_data;

  modport master (
    output cmd_valid, cmd_pre, cmd_len, cmd_change, cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_pre, cmd_len, cmd_change, cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/ivl_uvm_win_event_gen.sv
// Window event generator for exercising a windowed checker.
// One accepted command produces: cmd_pre idle cycles, a one-cycle
// start_event, max(cmd_len,1) open cycles (test_expr optionally updated on
// the first one), then a one-cycle end_event/done carrying exp_fire, the
// value the checker is expected to report (1 when test_expr did not change).
// Ports:
//   clock, reset : sole clock, asynchronous active-high reset
//   cmd          : command channel (slave side)
//   enable       : checker enable, high whenever out of reset
//   start_event  : window-open pulse
//   end_event    : window-close pulse
//   test_expr    : monitored data, persists across commands
//   exp_fire     : expected checker fire, meaningful with end_event only
//   busy         : command in progress
//   done         : completion pulse
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | waiting for a command, cmd_ready high
// PRE   | counting down cmd_pre idle cycles
// START | start_event cycle
// OPEN  | window open for max(cmd_len,1) cycles
// END   | end_event/done/exp_fire cycle
module ivl_uvm_win_event_gen #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  ivl_uvm_win_event_gen_if.slave  cmd,
  output logic                    enable,
  output logic                    start_event,
  output logic                    end_event,
  output logic [WIDTH-1:0]        test_expr,
  output logic                    exp_fire,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_START = 3'd2,
    S_OPEN  = 3'd3,
    S_END   = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic             ready_q;
  logic             accept;

  logic [CNT_W-1:0] len_q;
  logic             change_q;
  logic [WIDTH-1:0] data_q;
  logic             chg_q;

  logic             start_nxt;
  logic             end_nxt;
  logic             fire_nxt;
  logic             busy_nxt;
  logic             ready_nxt;

  assign cmd.cmd_ready = ready_q;

  // ready_q is low through reset and the first edge after it, so no command
  // can slip in before the generator has left reset cleanly.
  assign accept = cmd.cmd_valid && ready_q;

  // Next-state and counter. The counter is loaded with the full phase length
  // and the phase ends when it reads 1, so a load of 2^CNT_W-1 never wraps.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (cmd.cmd_pre != '0) begin
            state_nxt = S_PRE;
            cnt_nxt   = cmd.cmd_pre;
          end else begin
            state_nxt = S_START;
          end
        end
      end
      S_PRE: begin
        if (cnt <= CNT_W'(1)) begin
          state_nxt = S_START;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_START: begin
        state_nxt = S_OPEN;
        cnt_nxt   = (len_q == '0) ? CNT_W'(1) : len_q;
      end
      S_OPEN: begin
        if (cnt <= CNT_W'(1)) begin
          state_nxt = S_END;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_END: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so each output
  // lines up with the state it describes.
  always_comb begin
    start_nxt = (state_nxt == S_START);
    end_nxt   = (state_nxt == S_END);
    fire_nxt  = (state_nxt == S_END) && !chg_q;
    busy_nxt  = (state_nxt != S_IDLE);
    ready_nxt = (state_nxt == S_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ready_q     <= 1'b0;
      enable      <= 1'b0;
      start_event <= 1'b0;
      end_event   <= 1'b0;
      exp_fire    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      ready_q     <= ready_nxt;
      enable      <= 1'b1;
      start_event <= start_nxt;
      end_event   <= end_nxt;
      exp_fire    <= fire_nxt;
      busy        <= busy_nxt;
      done        <= end_nxt;
    end
  end

  // Command fields are only captured on accept; cmd_valid while busy is
  // ignored. chg is decided against test_expr as it stands at accept time,
  // since that is the value the checker will have seen before the window.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      len_q    <= '0;
      change_q <= 1'b0;
      data_q   <= '0;
      chg_q    <= 1'b0;
    end else if (accept) begin
      len_q    <= cmd.cmd_len;
      change_q <= cmd.cmd_change;
      data_q   <= cmd.cmd_data;
      chg_q    <= cmd.cmd_change && (cmd.cmd_data != test_expr);
    end
  end

  // START always moves to OPEN, so updating on the START edge makes the new
  // value visible on the first OPEN cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      test_expr <= '0;
    end else if (state == S_START && change_q) begin
      test_expr <= data_q;
    end
  end

endmodule

// File: tb/tb_ivl_uvm_win_event_gen.sv
module tb_ivl_uvm_win_event_gen;
  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  ivl_uvm_win_event_gen_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) ifc ();

  logic             enable, start_event, end_event, exp_fire, busy, done;
  logic [WIDTH-1:0] test_expr;

  ivl_uvm_win_event_gen #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .cmd         (ifc),
    .enable      (enable),
    .start_event (start_event),
    .end_event   (end_event),
    .test_expr   (test_expr),
    .exp_fire    (exp_fire),
    .busy        (busy),
    .done        (done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: a command accepted at an edge occupies cycles
  // k = 1..total after it, total = pre + max(len,1) + 2. start_event sits at
  // k = pre+1, the new test_expr appears at k = pre+2, end_event at k = total.
  int         m_k = 0;
  int         m_total = 0;
  int         m_pre = 0;
  bit         m_ready = 0;
  bit         m_enable = 0;
  bit         m_chg = 0;
  bit         m_change = 0;
  logic [3:0] m_data = '0;
  logic [3:0] m_te = '0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_k = 0; m_total = 0; m_pre = 0;
      m_ready = 0; m_enable = 0; m_chg = 0; m_te = '0;
    end else begin
      m_enable = 1;
      if (m_k == 0) begin
        if (m_ready && ifc.cmd_valid === 1'b1) begin
          m_pre    = int'(ifc.cmd_pre);
          m_total  = m_pre + ((ifc.cmd_len == 0) ? 1 : int'(ifc.cmd_len)) + 2;
          m_change = ifc.cmd_change;
          m_data   = ifc.cmd_data;
          m_chg    = ifc.cmd_change && (ifc.cmd_data != m_te);
          m_k      = 1;
          m_ready  = 0;
        end else begin
          m_ready = 1;
        end
      end else if (m_k == m_total) begin
        m_k = 0;
        m_ready = 1;
      end else begin
        m_k++;
      end
      if (m_k != 0 && m_k == m_pre + 2 && m_change) m_te = m_data;
    end
  end

  always @(negedge clock) begin
    bit e_start, e_end;
    e_start = (m_k != 0) && (m_k == m_pre + 1);
    e_end   = (m_k != 0) && (m_k == m_total);
    check("cmd_ready",   ifc.cmd_ready, m_ready);
    check("enable",      enable,        m_enable);
    check("start_event", start_event,   e_start);
    check("end_event",   end_event,     e_end);
    check("done",        done,          e_end);
    check("exp_fire",    exp_fire,      e_end && !m_chg);
    check("busy",        busy,          m_k != 0);
    check("test_expr",   test_expr,     m_te);
  end

  task automatic wait_ready();
    int guard = 0;
    while (ifc.cmd_ready !== 1'b1 && guard < 1000) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 1000) check("ready_timeout", 0, 1);
  endtask

  // Issue one command from an idle generator and report when its events
  // appear, counted in cycles after the accepting edge.
  task automatic run_cmd(input int pre, input int len, input bit change,
                         input logic [3:0] data, output int t_start,
                         output int t_end, output logic fire,
                         output logic [3:0] te_open);
    wait_ready();
    ifc.cmd_pre    = CNT_W'(pre);
    ifc.cmd_len    = CNT_W'(len);
    ifc.cmd_change = change;
    ifc.cmd_data   = data;
    ifc.cmd_valid  = 1'b1;
    @(negedge clock);
    ifc.cmd_valid = 1'b0;
    t_start = -1; t_end = -1; fire = 1'bx; te_open = 'x;
    for (int n = 1; n <= 600; n++) begin
      if (start_event === 1'b1 && t_start < 0) t_start = n;
      if (t_start > 0 && n == t_start + 1) te_open = test_expr;
      if (end_event === 1'b1) begin
        t_end = n;
        fire  = exp_fire;
        break;
      end
      @(negedge clock);
    end
  endtask

  initial begin
    int ts, te;
    logic f;
    logic [3:0] tx;
    int s2, e1, e2;
    logic f1, f2, r4;
    logic [3:0] te1, te2;

    ifc.cmd_valid = 0; ifc.cmd_pre = '0; ifc.cmd_len = '0;
    ifc.cmd_change = 0; ifc.cmd_data = '0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_ready", ifc.cmd_ready, 0);
    check("rst_enable", enable, 0);
    check("rst_busy", busy, 0);
    check("rst_test_expr", test_expr, 0);
    reset = 1'b0;
    @(negedge clock);
    check("ready_after_release", ifc.cmd_ready, 1);
    check("enable_after_release", enable, 1);

    run_cmd(0, 1, 1, 4'b1000, ts, te, f, tx);
    check("setup_end", te, 3);
    check("setup_fire", f, 0);
    check("setup_te", tx, 4'b1000);

    run_cmd(2, 3, 1, 4'b0100, ts, te, f, tx);
    check("r40_start", ts, 3);
    check("r40_te", tx, 4'b0100);
    check("r40_end", te, 7);
    check("r40_fire", f, 0);

    run_cmd(0, 2, 0, 4'b1111, ts, te, f, tx);
    check("r41_start", ts, 1);
    check("r41_end", te, 4);
    check("r41_fire", f, 1);
    check("r41_te", test_expr, 4'b0100);

    run_cmd(1, 1, 1, 4'b0100, ts, te, f, tx);
    check("r42_fire", f, 1);

    run_cmd(0, 0, 0, 4'b0000, ts, te, f, tx);
    check("r43_len0_end", te, 3);
    run_cmd(0, 1, 0, 4'b0000, ts, te, f, tx);
    check("r43_len1_end", te, 3);
    run_cmd(255, 0, 0, 4'b0000, ts, te, f, tx);
    check("r43_pre255_start", ts, 256);
    check("r43_pre255_end", te, 258);

    // Reset during OPEN
    wait_ready();
    ifc.cmd_pre = '0; ifc.cmd_len = 8'd5; ifc.cmd_change = 1; ifc.cmd_data = 4'b0110;
    ifc.cmd_valid = 1'b1;
    @(negedge clock);
    ifc.cmd_valid = 1'b0;
    @(negedge clock);
    check("r44_in_open", busy, 1);
    #1 reset = 1'b1;
    #1;
    check("r44_busy", busy, 0);
    check("r44_done", done, 0);
    check("r44_end", end_event, 0);
    check("r44_enable", enable, 0);
    check("r44_ready", ifc.cmd_ready, 0);
    check("r44_test_expr", test_expr, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("r44_ready_after", ifc.cmd_ready, 1);

    // Back-to-back with cmd_valid held, fields and valid disturbed while busy
    wait_ready();
    ifc.cmd_pre = '0; ifc.cmd_len = 8'd1; ifc.cmd_change = 1; ifc.cmd_data = 4'b0011;
    ifc.cmd_valid = 1'b1;
    s2 = -1; e1 = -1; e2 = -1; f1 = 1'bx; f2 = 1'bx; te1 = 'x; te2 = 'x; r4 = 1'bx;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clock);
      if (n == 1) ifc.cmd_data = 4'b1100;
      if (n == 2) ifc.cmd_valid = 1'b0;
      if (n == 3) ifc.cmd_valid = 1'b1;
      if (n == 4) r4 = ifc.cmd_ready;
      if (n == 5) ifc.cmd_valid = 1'b0;
      if (start_event === 1'b1 && n > 1 && s2 < 0) s2 = n;
      if (end_event === 1'b1) begin
        if (e1 < 0) begin e1 = n; f1 = exp_fire; te1 = test_expr; end
        else if (e2 < 0) begin e2 = n; f2 = exp_fire; te2 = test_expr; end
      end
    end
    check("r45_first_end", e1, 3);
    check("r45_first_te", te1, 4'b0011);
    check("r45_first_fire", f1, 0);
    check("r45_ready_after_done", r4, 1);
    check("r45_second_start", s2, 5);
    check("r45_second_end", e2, 7);
    check("r45_second_te", te2, 4'b1100);
    check("r45_second_fire", f2, 0);

    // Randomized traffic checked cycle by cycle against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      ifc.cmd_valid  = ($urandom_range(0, 2) != 0);
      ifc.cmd_pre    = ($urandom_range(0, 9) == 0) ? CNT_W'($urandom_range(10, 40))
                                                   : CNT_W'($urandom_range(0, 3));
      ifc.cmd_len    = CNT_W'($urandom_range(0, 4));
      ifc.cmd_change = 1'($urandom_range(0, 1));
      ifc.cmd_data   = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
      end
    end
    ifc.cmd_valid = 1'b0;
    repeat (60) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
